// File: rtl/mc_pkg.sv
// mc_pkg: shared types and encodings for the multi-cycle MIPS-subset controller.
package mc_pkg;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       ir_write;
        logic [1:0] pc_source;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] memto_reg;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_op;
        logic [3:0] alu_op;
        logic       lui_op;
    } mc_ctrl_t;

    typedef enum logic [2:0] {
        MC_IF   = 3'd0,
        MC_ID   = 3'd1,
        MC_EX   = 3'd2,
        MC_MEM  = 3'd3,
        MC_WB   = 3'd4,
        MC_HALT = 3'd5,
        MC_TRAP = 3'd6
    } mc_state_e;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_FUNCT = 4'd2;
    localparam logic [3:0] ALU_AND   = 4'd3;
    localparam logic [3:0] ALU_OR    = 4'd4;
    localparam logic [3:0] ALU_SLT   = 4'd5;
    localparam logic [3:0] ALU_SLTU  = 4'd6;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    function automatic logic mc_is_r_alu(input logic [5:0] fn);
        return fn inside {FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
                          FN_XOR, FN_NOR, FN_SLT, FN_SLTU};
    endfunction

    function automatic logic mc_is_shift(input logic [5:0] fn);
        return fn inside {FN_SLL, FN_SRL, FN_SRA};
    endfunction

    function automatic logic mc_is_imm(input logic [5:0] op);
        return op inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI};
    endfunction

    function automatic logic [3:0] mc_imm_alu_op(input logic [5:0] op);
        return (op == OP_SLTI)  ? ALU_SLT  :
               (op == OP_SLTIU) ? ALU_SLTU :
               (op == OP_ANDI)  ? ALU_AND  :
               (op == OP_ORI)   ? ALU_OR   : ALU_ADD;
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: per-access memory wait counter; expired_o flags ACK_TIMEOUT reached (0 disables).
module mc_wait_timer #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_at_max;

    assign w_at_max  = (r_cnt == CW'(ACK_TIMEOUT));
    assign expired_o = (ACK_TIMEOUT != 0) && w_at_max;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_cnt <= '0;
        else if (clr_i)
            r_cnt <= '0;
        else if (en_i && !w_at_max)
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS-subset control FSM with memory handshake and ack timeout.
// Define MC_CTRL_ILLEGAL_TRAP_EN to trap undecoded instructions instead of retiring them as NOPs.
module mc_ctrl_fsm
    import mc_pkg::*;
#(
    parameter int ACK_TIMEOUT = 15,
    parameter int STATE_W     = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op_i,
    input  logic [5:0]         funct_i,
    input  logic               mem_ack_i,
    output logic               mem_req_o,
    output mc_ctrl_t           ctrl_o,
    output logic [STATE_W-1:0] state_o,
    output logic               retire_o,
    output logic               bus_error_o,
    output logic               trap_o
);

    localparam logic [2:0] ST_IF   = MC_IF;
    localparam logic [2:0] ST_ID   = MC_ID;
    localparam logic [2:0] ST_EX   = MC_EX;
    localparam logic [2:0] ST_MEM  = MC_MEM;
    localparam logic [2:0] ST_WB   = MC_WB;
    localparam logic [2:0] ST_HALT = MC_HALT;
    localparam logic [2:0] ST_TRAP = MC_TRAP;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic [2:0] r_state, w_next;
    logic       r_bus_err, r_trap;
    logic       w_wait, w_en, w_clr, w_expired, w_timeout;
    logic       w_rtype, w_r_alu, w_shift, w_jr, w_jalr;
    logic       w_lw, w_sw, w_beq, w_j, w_jal, w_lui, w_imm, w_legal;
    mc_ctrl_t   w_ctrl;
    logic       w_req, w_retire;

    assign w_rtype = (op_i == OP_RTYPE);
    assign w_r_alu = w_rtype && mc_is_r_alu(funct_i);
    assign w_shift = w_rtype && mc_is_shift(funct_i);
    assign w_jr    = w_rtype && (funct_i == FN_JR);
    assign w_jalr  = w_rtype && (funct_i == FN_JALR);
    assign w_lw    = (op_i == OP_LW);
    assign w_sw    = (op_i == OP_SW);
    assign w_beq   = (op_i == OP_BEQ);
    assign w_j     = (op_i == OP_J);
    assign w_jal   = (op_i == OP_JAL);
    assign w_lui   = (op_i == OP_LUI);
    assign w_imm   = mc_is_imm(op_i);
    assign w_legal = w_r_alu || w_shift || w_jr || w_jalr || w_lw || w_sw ||
                     w_beq || w_j || w_jal || w_lui || w_imm;

    // Any state change clears the counter, so IF/MEM always start counting from zero.
    assign w_wait    = (r_state == ST_IF) || (r_state == ST_MEM);
    assign w_en      = w_wait && !mem_ack_i;
    assign w_timeout = w_en && w_expired;
    assign w_clr     = (w_next != r_state);

    mc_wait_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (w_clr),
        .en_i      (w_en),
        .expired_o (w_expired)
    );

    always_comb begin
        w_ctrl   = '0;
        w_req    = 1'b0;
        w_retire = 1'b0;
        w_next   = r_state;
        case (r_state)
            ST_IF: begin
                w_req           = 1'b1;
                w_ctrl.mem_read = 1'b1;
                if (mem_ack_i) begin
                    w_ctrl.ir_write  = 1'b1;
                    w_ctrl.pc_write  = 1'b1;
                    w_ctrl.alu_src_b = 2'd1;
                    w_next           = ST_ID;
                end else if (w_expired) begin
                    w_next = ST_HALT;
                end
            end
            ST_ID: begin
                w_ctrl.alu_src_b = 2'd3;
                w_ctrl.ext_op    = 1'b1;
                w_retire         = !w_legal && !TRAP_EN;
                w_next           = w_legal ? ST_EX : (TRAP_EN ? ST_TRAP : ST_IF);
            end
            ST_EX: begin
                if (w_r_alu || w_shift) begin
                    w_ctrl.alu_src_a = w_shift ? 2'd2 : 2'd1;
                    w_ctrl.alu_op    = ALU_FUNCT;
                    w_next           = ST_WB;
                end else if (w_imm || w_lui) begin
                    w_ctrl.alu_src_a = 2'd1;
                    w_ctrl.alu_src_b = 2'd2;
                    w_ctrl.ext_op    = !(op_i == OP_ANDI || op_i == OP_ORI);
                    w_ctrl.alu_op    = mc_imm_alu_op(op_i);
                    w_ctrl.lui_op    = w_lui;
                    w_next           = ST_WB;
                end else if (w_lw || w_sw) begin
                    w_ctrl.alu_src_a = 2'd1;
                    w_ctrl.alu_src_b = 2'd2;
                    w_ctrl.ext_op    = 1'b1;
                    w_next           = ST_MEM;
                end else begin
                    w_ctrl.alu_src_a     = w_beq ? 2'd1 : 2'd0;
                    w_ctrl.alu_op        = w_beq ? ALU_SUB : ALU_ADD;
                    w_ctrl.pc_write_cond = w_beq;
                    w_ctrl.pc_write      = w_j || w_jal || w_jr || w_jalr;
                    w_ctrl.pc_source     = w_beq ? 2'd1 : (w_j || w_jal) ? 2'd2 : 2'd3;
                    w_ctrl.reg_write     = w_jal || w_jalr;
                    w_ctrl.reg_dst       = w_jal ? 2'd2 : w_jalr ? 2'd1 : 2'd0;
                    w_ctrl.memto_reg     = (w_jal || w_jalr) ? 2'd2 : 2'd0;
                    w_retire             = 1'b1;
                    w_next               = ST_IF;
                end
            end
            ST_MEM: begin
                w_req            = 1'b1;
                w_ctrl.iord      = 1'b1;
                w_ctrl.mem_read  = w_lw;
                w_ctrl.mem_write = w_sw;
                if (mem_ack_i) begin
                    w_retire = !w_lw;
                    w_next   = w_lw ? ST_WB : ST_IF;
                end else if (w_expired) begin
                    w_next = ST_HALT;
                end
            end
            ST_WB: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.reg_dst   = w_rtype ? 2'd1 : 2'd0;
                w_ctrl.memto_reg = w_lw ? 2'd0 : 2'd1;
                w_retire         = 1'b1;
                w_next           = ST_IF;
            end
            ST_HALT, ST_TRAP: w_next = r_state;
            default:          w_next = ST_IF;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IF;
            r_bus_err <= 1'b0;
            r_trap    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_timeout)
                r_bus_err <= 1'b1;
            if (TRAP_EN && r_state == ST_ID && !w_legal)
                r_trap <= 1'b1;
        end
    end

    assign mem_req_o   = w_req;
    assign ctrl_o      = w_ctrl;
    assign retire_o    = w_retire;
    assign state_o     = STATE_W'(r_state);
    assign bus_error_o = r_bus_err;
    assign trap_o      = r_trap;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: directed self-checking bench for mc_ctrl_fsm (ACK_TIMEOUT=4).
module tb_mc_ctrl_fsm;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       ir_write;
        logic [1:0] pc_source;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] memto_reg;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_op;
        logic [3:0] alu_op;
        logic       lui_op;
    } tb_ctrl_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  op_i = '0;
    logic [5:0]  funct_i = '0;
    logic        mem_ack_i = 1'b0;
    logic        mem_req_o;
    logic [22:0] ctrl_o;
    logic [2:0]  state_o;
    logic        retire_o;
    logic        bus_error_o;
    logic        trap_o;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc;
    logic [63:0] trace;
    tb_ctrl_t    snap [8];
    tb_ctrl_t    e;

    mc_ctrl_fsm #(.ACK_TIMEOUT(4), .STATE_W(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .op_i        (op_i),
        .funct_i     (funct_i),
        .mem_ack_i   (mem_ack_i),
        .mem_req_o   (mem_req_o),
        .ctrl_o      (ctrl_o),
        .state_o     (state_o),
        .retire_o    (retire_o),
        .bus_error_o (bus_error_o),
        .trap_o      (trap_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    // Runs one instruction from IF; ack arrives after if_w / mem_w wait cycles.
    // trace holds (state+1) per cycle, one nibble each; snap keeps the last ctrl seen per state.
    task automatic run(input logic [5:0] op, input logic [5:0] fn, input int if_w, input int mem_w);
        int         w;
        logic [2:0] prev;
        logic       done;
        op_i = op;
        funct_i = fn;
        cyc = 0;
        w = 0;
        done = 1'b0;
        trace = '0;
        prev = state_o;
        while (!done && cyc < 40) begin
            if (state_o != prev) w = 0;
            prev = state_o;
            mem_ack_i = (state_o == 3'd0) ? (w >= if_w) : (state_o == 3'd3) ? (w >= mem_w) : 1'b1;
            #1;
            snap[state_o] = ctrl_o;
            trace = {trace[59:0], 1'b0, state_o + 3'd1};
            cyc++;
            done = retire_o;
            step();
            w++;
        end
        check("retire_seen", {63'd0, done}, 64'd1);
    endtask

    initial begin
        #1;
        e = '0;
        e.mem_read = 1'b1;
        check("rst_state", state_o, 0);
        check("rst_req", mem_req_o, 1);
        check("rst_ctrl", ctrl_o, e);
        check("rst_retire", retire_o, 0);
        check("rst_buserr", bus_error_o, 0);
        check("rst_trap", trap_o, 0);
        step();
        reset = 1'b1;

        run(6'h00, 6'h21, 0, 0);
        check("addu_cyc", cyc, 4);
        check("addu_trace", trace, 64'h1235);
        e = '0; e.pc_write = 1; e.ir_write = 1; e.mem_read = 1; e.alu_src_b = 2'd1;
        check("if_ack_ctrl", snap[0], e);
        e = '0; e.alu_src_b = 2'd3; e.ext_op = 1;
        check("id_ctrl", snap[1], e);
        e = '0; e.alu_src_a = 2'd1; e.alu_op = 4'd2;
        check("addu_ex", snap[2], e);
        e = '0; e.reg_write = 1; e.reg_dst = 2'd1; e.memto_reg = 2'd1;
        check("addu_wb", snap[4], e);
        check("addu_next", state_o, 0);

        run(6'h23, 6'h00, 2, 3);
        check("lw_cyc", cyc, 10);
        check("lw_trace", trace, 64'h11_1234_4445);
        e = '0; e.iord = 1; e.mem_read = 1;
        check("lw_mem", snap[3], e);
        e = '0; e.reg_write = 1;
        check("lw_wb", snap[4], e);

        run(6'h2B, 6'h00, 0, 0);
        check("sw_cyc", cyc, 4);
        e = '0; e.iord = 1; e.mem_write = 1;
        check("sw_mem", snap[3], e);

        run(6'h04, 6'h00, 0, 0);
        check("beq_cyc", cyc, 3);
        e = '0; e.pc_write_cond = 1; e.pc_source = 2'd1; e.alu_src_a = 2'd1; e.alu_op = 4'd1;
        check("beq_ex", snap[2], e);

        run(6'h03, 6'h00, 0, 0);
        check("jal_cyc", cyc, 3);
        e = '0; e.pc_write = 1; e.pc_source = 2'd2; e.reg_write = 1; e.reg_dst = 2'd2; e.memto_reg = 2'd2;
        check("jal_ex", snap[2], e);

        run(6'h00, 6'h09, 0, 0);
        e = '0; e.pc_write = 1; e.pc_source = 2'd3; e.reg_write = 1; e.reg_dst = 2'd1; e.memto_reg = 2'd2;
        check("jalr_ex", snap[2], e);

        run(6'h0D, 6'h00, 0, 0);
        check("ori_cyc", cyc, 4);
        e = '0; e.alu_src_a = 2'd1; e.alu_src_b = 2'd2; e.alu_op = 4'd4;
        check("ori_ex", snap[2], e);
        e = '0; e.reg_write = 1; e.memto_reg = 2'd1;
        check("ori_wb", snap[4], e);

        run(6'h0A, 6'h00, 0, 0);
        e = '0; e.alu_src_a = 2'd1; e.alu_src_b = 2'd2; e.ext_op = 1; e.alu_op = 4'd5;
        check("slti_ex", snap[2], e);

        run(6'h0F, 6'h00, 0, 0);
        e = '0; e.alu_src_a = 2'd1; e.alu_src_b = 2'd2; e.ext_op = 1; e.lui_op = 1;
        check("lui_ex", snap[2], e);

        run(6'h00, 6'h00, 0, 0);
        e = '0; e.alu_src_a = 2'd2; e.alu_op = 4'd2;
        check("sll_ex", snap[2], e);

        // Ack in the cycle the count equals ACK_TIMEOUT (4 prior waits) is still accepted.
        run(6'h00, 6'h21, 4, 0);
        check("edge_cyc", cyc, 8);
        check("edge_trace", trace, 64'h1111_1235);
        check("edge_buserr", bus_error_o, 0);

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        op_i = 6'h3F;
        mem_ack_i = 1'b1;
        step();
        check("ill_id_retire", retire_o, 0);
        step();
        check("trap_state", state_o, 6);
        check("trap_flag", trap_o, 1);
        check("trap_ctrl", ctrl_o, 0);
        check("trap_req", mem_req_o, 0);
        step();
        check("trap_stay", state_o, 6);
        do_reset();
        check("trap_cleared", trap_o, 0);
`else
        run(6'h3F, 6'h00, 0, 0);
        check("nop_cyc", cyc, 2);
        check("nop_trace", trace, 64'h12);
        check("nop_trap", trap_o, 0);
`endif

        // Asynchronous reset while a load is waiting in MEM.
        op_i = 6'h23;
        funct_i = 6'h00;
        mem_ack_i = 1'b1;
        step();
        step();
        step();
        mem_ack_i = 1'b0;
        step();
        check("mid_in_mem", state_o, 3);
        #2;
        reset = 1'b0;
        #1;
        e = '0; e.mem_read = 1;
        check("mid_rst_state", state_o, 0);
        check("mid_rst_ctrl", ctrl_o, e);
        step();
        reset = 1'b1;

        // No ack: counts 0..4 in IF, the un-acked cycle at 4 sends the FSM to HALT.
        op_i = 6'h00;
        mem_ack_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("to_if_%0d", i), state_o, 0);
            step();
        end
        check("to_halt", state_o, 5);
        check("to_buserr", bus_error_o, 1);
        check("to_ctrl", ctrl_o, 0);
        check("to_req", mem_req_o, 0);
        mem_ack_i = 1'b1;
        step();
        step();
        check("halt_stay", state_o, 5);
        check("halt_ctrl", ctrl_o, 0);
        check("halt_retire", retire_o, 0);
        do_reset();
        check("rst_clears_err", bus_error_o, 0);
        check("rst_back_if", state_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Parametrised multi-cycle control unit for the MIPS-subset multi-cycle processor. It replaces the fixed single-cycle-memory controller with an FSM that handshakes with a variable-latency instruction/data memory. It adds an acknowledge timeout and an optional illegal-opcode trap. It sits between the instruction register (opcode/funct inputs) and the datapath muxes and registers (packed control output).

## Interface
- `ACK_TIMEOUT`, default 15: maximum wait cycles for `mem_ack_i` per access; 0 disables the timeout. Counter width is `$clog2(ACK_TIMEOUT+1)` (minimum 1).
- `STATE_W`, default 3: width of `state_o`; must be at least 3.
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `op_i`, input, 6: IR opcode.
- `funct_i`, input, 6: IR funct.
- `mem_ack_i`, input, 1: memory completed the current access this cycle (read data valid this cycle).
- `mem_req_o`, output, 1: memory access requested (IF or MEM state).
- `ctrl_o`, output, 23: packed `mc_ctrl_t`.
- `state_o`, output, STATE_W: current state encoding.
- `retire_o`, output, 1: one-cycle pulse in the final cycle of each instruction.
- `bus_error_o`, output, 1: sticky; set on timeout.
- `trap_o`, output, 1: sticky; set on illegal opcode (0 when the trap feature is compiled out).

## Operation
- `mc_ctrl_t` fields, MSB to LSB: PCWrite, PCWriteCond, IorD, IRWrite, PCSource[1:0], RegWrite, RegDst[1:0], MemRead, MemWrite, MemtoReg[1:0], ALUSrcA[1:0], ALUSrcB[1:0], ExtOp, ALUOp[3:0], LuiOp.
- Any field not named for a state is 0.
- ALUOp encoding: 0 add, 1 sub, 2 funct-decoded, 3 and, 4 or, 5 slt, 6 sltu.
- Supported instructions:
  - R-type (op 0): ALU ops; shifts sll/srl/sra (funct 0/2/3); jr (0x08); jalr (0x09).
  - lw 0x23, sw 0x2B, beq 0x04, j 0x02, jal 0x03, lui 0x0F.
  - I-type ALU: addi 0x08, addiu 0x09, slti 0x0A, sltiu 0x0B, andi 0x0C, ori 0x0D.
- States: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5, TRAP=6.
- IF: mem_req, MemRead=1, IorD=0.
  - When `mem_ack_i` is high: IRWrite=1, PCWrite=1, ALUSrcB=1, ALUOp=add, PCSource=0, then go to ID.
  - Otherwise stay in IF.
- ID: ALUSrcA=0, ALUSrcB=3, ExtOp=1, ALUOp=add (branch target into ALUOut), then go to EX.
  - Illegal opcode/funct goes to TRAP when the trap feature is enabled, otherwise to IF with `retire_o`.
- EX:
  - R-type ALU: ALUSrcA=1 (2 for shifts), ALUSrcB=0, ALUOp=2; then WB.
  - I-type: ALUSrcA=1, ALUSrcB=2. ExtOp=0 for andi/ori, 1 otherwise. ALUOp per opcode. lui uses LuiOp=1 with add. Then WB.
  - lw/sw: ALUSrcA=1, ALUSrcB=2, ExtOp=1, add; then MEM.
  - beq: ALUSrcA=1, ALUSrcB=0, sub, PCWriteCond=1, PCSource=1; then IF with retire.
  - j/jal: PCWrite, PCSource=2. jr/jalr: PCWrite, PCSource=3.
  - jal also asserts RegWrite, RegDst=2, MemtoReg=2. jalr asserts RegWrite, RegDst=1, MemtoReg=2.
  - All jumps then go to IF with retire.
- MEM: mem_req, IorD=1; MemRead for lw, MemWrite for sw.
  - On ack: lw goes to WB; sw goes to IF with retire.
- WB: RegWrite=1, then IF with retire.
  - lw: RegDst=0, MemtoReg=0.
  - R-type: RegDst=1, MemtoReg=1.
  - I-type: RegDst=0, MemtoReg=1.
- Timeout: the wait counter clears on entry to IF or MEM and increments each un-acked cycle there.
  - When the count reaches ACK_TIMEOUT with no ack, go to HALT and set `bus_error_o`.
- HALT/TRAP: `ctrl_o`=0 and `mem_req_o`=0. Only reset leaves these states.

## Timing
- `ctrl_o`, `mem_req_o` and `retire_o` are combinational from registered state, `op_i`, `funct_i` and `mem_ack_i`. `state_o` and sticky flags are registered.
- Reset (reset=0, asynchronous): state=IF, counter=0, `bus_error_o`=0, `trap_o`=0.
  - Outputs then equal IF with no ack: `mem_req_o`=1, MemRead=1, all else 0, `retire_o`=0.
- Zero-wait latencies: R/I-type 4 cycles, lw 5, sw 4, beq/jumps 3.
  - Each memory wait cycle adds 1.
- An ack in the same cycle the counter reaches ACK_TIMEOUT is accepted; no error is raised.
- `mem_ack_i` outside IF/MEM is ignored.
- Reset mid-access aborts the access; no PC or IR write occurs.

## Configuration
- `MC_CTRL_ILLEGAL_TRAP_EN` defined: undecoded op/funct in ID goes to TRAP and sets `trap_o`.
- Not defined: undecoded instructions retire as NOPs (ID to IF, no writes); `trap_o` is tied to 0 and TRAP is unreachable.

## Structure
- Package `mc_pkg` holds:
  - `mc_ctrl_t` packed struct.
  - State enum.
  - ALUOp localparams.
  - Opcode and funct constants.
- One sub-module, `mc_wait_timer`: counter with clear/enable, `expired` output, and ACK_TIMEOUT parameter.

## Test plan
- Reset release, ack tied to 1, `addu $4,$2,$3` (op 0, funct 0x21): states 0,1,2,4,0. In EX, ALUOp=2. In WB, RegDst=1 and MemtoReg=1. One retire pulse.
- lw with IF ack after 2 waits and MEM ack after 3: 10 cycles total. In MEM, IorD=1 and MemRead=1. In WB, MemtoReg=0.
- beq: exactly 3 cycles. In EX, PCWriteCond=1, PCSource=1, ALUOp=1.
- jal: in EX, PCSource=2, RegDst=2, MemtoReg=2, RegWrite=1.
- ACK_TIMEOUT=4, ack never asserted: HALT entered after 4 IF wait cycles; `bus_error_o`=1; `ctrl_o`=0 until reset.
- Op 0x3F: TRAP with `trap_o`=1 when the macro is defined; otherwise a NOP retire after 2 cycles.
